adc_two_step_seq: RTL and testbench
===================================

// Module: adc_two_step_seq
// PURPOSE
// Conversion sequencer for the two-step (coarse/fine) 6-comparator flash ADC.
// - Drives the track/hold, comparator latch strobe and residue DAC code.
// - Encodes the coarse then fine thermometer words through an internal
//   6->3 thermometer encoder and combines them into a 6-bit result.
// - Presents the result on a valid/ready output port backed by a 1-deep buffer.
// - Sits between the analog front-end comparators and the digital output link.
// PARAMETERS
// SAMPLE_CYC  4  cycles sample_o is held high (track phase); legal range >=1
// SETTLE_CYC  2  cycles of comparator/DAC settling before each latch; legal range >=1
// PORTS
// clk         in   1  system clock, all logic on rising edge
// rst         in   1  synchronous reset, active high
// start       in   1  request one conversion; sampled only in IDLE
// busy        out  1  high in every state except IDLE
// sample_o    out  1  track/hold control, high during SAMPLE
// cmp_latch   out  1  comparator latch strobe, high during C_LATCH and F_LATCH
// comp_therm  in   6  comparator thermometer word (already synchronised to clk)
// dac_code    out  3  residue DAC code
// dout        out  6  conversion result, coarse*6 + fine, range 0..35
// dout_valid  out  1  dout holds an unread result
// dout_ready  in   1  consumer accepts dout when dout_valid is high
// bubble_err  out  1  sticky: a non-thermometer comparator word was captured
// overrun     out  1  sticky: an unread result was overwritten
// err_clr     in   1  clears bubble_err and overrun
// BEHAVIOUR
// - Reset: all outputs 0; FSM goes to IDLE; any pending result is discarded.
//   This holds when rst is asserted mid-conversion.
// - FSM and state durations (all outputs registered):
//   - IDLE -> SAMPLE on start.
//   - SAMPLE:   SAMPLE_CYC cycles.
//   - C_SETTLE: SETTLE_CYC cycles.
//   - C_LATCH:  1 cycle.
//   - F_SETTLE: SETTLE_CYC cycles.
//   - F_LATCH:  1 cycle.
//   - DONE:     1 cycle, then IDLE.
// - One down-counter, reloaded on every state entry, times SAMPLE and both
//   SETTLE states.
// - Capture points:
//   - comp_therm is captured into the coarse register on the edge that ends C_LATCH.
//   - comp_therm is captured into the fine register on the edge that ends F_LATCH.
// - dac_code equals the coarse register during F_SETTLE and F_LATCH, and 0 in
//   all other states. It updates on the edge entering F_SETTLE.
// - Encoder mapping (6-bit word -> 3-bit value):
//   - 000000->0, 000001->1, 000011->2, 000111->3, 001111->4, 011111->5.
//   - 111111->5 (overrange saturation, no error).
//   - Any other word -> 5, and bubble_err is set on the capture edge.
// - Result: dout = coarse*6 + fine. Computed unsigned and zero-extended to 6
//   bits; no overflow is possible.
// - Latency: dout_valid rises SAMPLE_CYC + 2*SETTLE_CYC + 3 edges after the edge
//   that samples start (11 edges at defaults). dout is loaded on that same edge
//   that ends DONE.
// - Throughput with start held high: one conversion per SAMPLE_CYC + 2*SETTLE_CYC + 4 cycles.
// - start while busy is ignored; it is not queued.
// - Output handshake:
//   - A transfer occurs on any edge where dout_valid and dout_ready are both high.
//   - After a transfer dout_valid clears unless a DONE load occurs on the same edge.
//   - dout holds its value while dout_valid is low.
//   - DONE load while dout_valid=1 and dout_ready=1: the new result loads,
//     dout_valid stays 1, no overrun.
//   - DONE load while dout_valid=1 and dout_ready=0: the new result overwrites
//     dout, dout_valid stays 1, overrun is set.
// - Sticky flags:
//   - err_clr clears bubble_err and overrun on the next edge.
//   - If a set event and err_clr occur on the same edge, the flag ends up set.
// TESTING
// - Defaults, coarse word 000111, fine word 000011 -> dac_code=3 during the F
//   phase, dout=20, dout_valid rises 11 edges after start.
// - dout_ready=0, two conversions back-to-back -> dout=second result, overrun=1;
//   repeat with dout_ready=1 on the DONE edge -> overrun stays 0.
// - Coarse word 000101 -> coarse=5, bubble_err=1; err_clr pulse -> bubble_err=0.
// - Both words 111111 -> dout=35, bubble_err=0.
// - start pulsed during F_SETTLE is ignored; rst asserted in F_SETTLE -> next
//   cycle busy=0, sample_o=0, dac_code=0, dout_valid=0.
// - SAMPLE_CYC=1, SETTLE_CYC=1, start held high -> latency 6 edges, one result
//   every 7 cycles.

Source files
------------

// File: rtl/adc_two_step_seq_if.sv
// rtl/adc_two_step_seq_if.sv - result output port of the two-step ADC sequencer
// Carries the 6-bit conversion result with its valid/ready handshake.
interface adc_two_step_seq_if;
  logic [5:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/adc_two_step_seq.sv
// rtl/adc_two_step_seq.sv - coarse/fine conversion sequencer for a 6-comparator two-step flash ADC
// Times track/hold, latch strobes and residue DAC, encodes both thermometer words, buffers one result.
module adc_two_step_seq #(
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       sample_o,
  output logic                       cmp_latch,
  input  logic [5:0]                 comp_therm,
  output logic [2:0]                 dac_code,
  output logic                       bubble_err,
  output logic                       overrun,
  input  logic                       err_clr,
  adc_two_step_seq_if.master         out_if
);

  localparam int MAX_CYC = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, C_SETTLE, C_LATCH, F_SETTLE, F_LATCH, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          sample_q, sample_d;
  logic          cmp_latch_q, cmp_latch_d;
  logic [2:0]    dac_code_q, dac_code_d;
  logic [2:0]    coarse_q, coarse_d;
  logic [2:0]    fine_q, fine_d;
  logic [5:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          bubble_err_q, bubble_err_d;
  logic          overrun_q, overrun_d;
  logic [3:0]    enc;
  logic          capture;
  logic          load;

  // Returns {bubble, value}; a non-thermometer word saturates to 5 and flags a bubble.
  function automatic logic [3:0] therm_enc(input logic [5:0] w);
    case (w)
      6'b000000: therm_enc = 4'b0000;
      6'b000001: therm_enc = 4'b0001;
      6'b000011: therm_enc = 4'b0010;
      6'b000111: therm_enc = 4'b0011;
      6'b001111: therm_enc = 4'b0100;
      6'b011111: therm_enc = 4'b0101;
      6'b111111: therm_enc = 4'b0101;
      default:   therm_enc = 4'b1101;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     if (start) state_d = SAMPLE;
      SAMPLE:   if (cnt_q == '0) state_d = C_SETTLE; else cnt_d = cnt_q - 1'b1;
      C_SETTLE: if (cnt_q == '0) state_d = C_LATCH;  else cnt_d = cnt_q - 1'b1;
      C_LATCH:  state_d = F_SETTLE;
      F_SETTLE: if (cnt_q == '0) state_d = F_LATCH;  else cnt_d = cnt_q - 1'b1;
      F_LATCH:  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d != state_q)
      cnt_d = (state_d == SAMPLE) ? CW'(SAMPLE_CYC - 1) : CW'(SETTLE_CYC - 1);

    enc      = therm_enc(comp_therm);
    capture  = (state_q == C_LATCH) || (state_q == F_LATCH);
    coarse_d = (state_q == C_LATCH) ? enc[2:0] : coarse_q;
    fine_d   = (state_q == F_LATCH) ? enc[2:0] : fine_q;

    busy_d      = (state_d != IDLE);
    sample_d    = (state_d == SAMPLE);
    cmp_latch_d = (state_d == C_LATCH) || (state_d == F_LATCH);
    // Uses coarse_d so the DAC shows the new coarse code on the very edge it is captured.
    dac_code_d  = ((state_d == F_SETTLE) || (state_d == F_LATCH)) ? coarse_d : 3'd0;

    load         = (state_q == DONE);
    dout_d       = load ? (({3'b000, coarse_q} * 6'd6) + {3'b000, fine_q}) : dout_q;
    dout_valid_d = load || (dout_valid_q && !out_if.dout_ready);

    bubble_err_d = (capture && enc[3]) || (bubble_err_q && !err_clr);
    overrun_d    = (load && dout_valid_q && !out_if.dout_ready) || (overrun_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      sample_q     <= 1'b0;
      cmp_latch_q  <= 1'b0;
      dac_code_q   <= 3'd0;
      coarse_q     <= 3'd0;
      fine_q       <= 3'd0;
      dout_q       <= 6'd0;
      dout_valid_q <= 1'b0;
      bubble_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      sample_q     <= sample_d;
      cmp_latch_q  <= cmp_latch_d;
      dac_code_q   <= dac_code_d;
      coarse_q     <= coarse_d;
      fine_q       <= fine_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      bubble_err_q <= bubble_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy              = busy_q;
  assign sample_o          = sample_q;
  assign cmp_latch         = cmp_latch_q;
  assign dac_code          = dac_code_q;
  assign bubble_err        = bubble_err_q;
  assign overrun           = overrun_q;
  assign out_if.dout       = dout_q;
  assign out_if.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_adc_two_step_seq.sv
// tb/tb_adc_two_step_seq.sv - directed self-checking bench for adc_two_step_seq
// Instance a uses default timing; instance b uses the minimum SAMPLE_CYC/SETTLE_CYC.
module tb_adc_two_step_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       busy_a, busy_b, smp_a, smp_b, cmp_a, cmp_b;
  logic [5:0] comp_a, comp_b;
  logic [2:0] dac_a, dac_b;
  logic       bub_a, bub_b, ovr_a, ovr_b;
  logic       clr_a, clr_b;
  logic       bub_e10;
  int         tests = 0;
  int         fails = 0;

  adc_two_step_seq_if if_a ();
  adc_two_step_seq_if if_b ();

  adc_two_step_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .sample_o(smp_a),
    .cmp_latch(cmp_a), .comp_therm(comp_a), .dac_code(dac_a), .bubble_err(bub_a),
    .overrun(ovr_a), .err_clr(clr_a), .out_if(if_a)
  );

  adc_two_step_seq #(.SAMPLE_CYC(1), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .sample_o(smp_b),
    .cmp_latch(cmp_b), .comp_therm(comp_b), .dac_code(dac_b), .bubble_err(bub_b),
    .overrun(ovr_b), .err_clr(clr_b), .out_if(if_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns just after the edge that ends DONE (edge 11 after the start-sampling edge).
  task automatic run_conv(input logic [5:0] cw, input logic [5:0] fw, input logic rdy_done,
                          input bit chk_lat, input logic [2:0] exp_dac);
    @(negedge clk);
    start_a = 1'b1;
    comp_a  = cw;
    @(negedge clk);
    start_a = 1'b0;
    check("sample_e0", smp_a, 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 6) check("cmp_latch_c", cmp_a, 1);
      if (k == 7) begin
        check("dac_f_phase", dac_a, exp_dac);
        comp_a = fw;
      end
      if (k == 10) begin
        bub_e10 = bub_a;
        if (chk_lat) check("valid_e10", if_a.dout_valid, 0);
        if_a.dout_ready = rdy_done;
      end
      if (k == 11) begin
        check("busy_e11", busy_a, 0);
        check("dac_e11", dac_a, 0);
        if (chk_lat) check("valid_e11", if_a.dout_valid, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    comp_a = 6'd0; comp_b = 6'b000001;
    clr_a = 1'b0; clr_b = 1'b0;
    bub_e10 = 1'b0;
    if_a.dout_ready = 1'b0;
    if_b.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_sample", smp_a, 0);
    check("rst_cmp", cmp_a, 0);
    check("rst_dac", dac_a, 0);
    check("rst_dout", if_a.dout, 0);
    check("rst_valid", if_a.dout_valid, 0);
    check("rst_bub", bub_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_valid_b", if_b.dout_valid, 0);
    rst = 1'b0;

    // 000111 / 000011 -> 3*6+2 = 20
    run_conv(6'b000111, 6'b000011, 1'b0, 1'b1, 3'd3);
    check("dout_20", if_a.dout, 20);
    check("ovr_20", ovr_a, 0);
    check("bub_20", bub_a, 0);
    @(negedge clk); if_a.dout_ready = 1'b1;
    @(negedge clk); if_a.dout_ready = 1'b0;
    check("valid_consumed", if_a.dout_valid, 0);
    check("dout_hold", if_a.dout, 20);

    // Two unread results: second overwrites and flags overrun
    run_conv(6'b000001, 6'b000001, 1'b0, 1'b1, 3'd1);
    check("dout_7", if_a.dout, 7);
    check("ovr_first", ovr_a, 0);
    run_conv(6'b000011, 6'b000000, 1'b0, 1'b0, 3'd2);
    check("dout_12", if_a.dout, 12);
    check("valid_12", if_a.dout_valid, 1);
    check("ovr_set", ovr_a, 1);
    @(negedge clk); clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    check("ovr_clr", ovr_a, 0);

    // Ready on the DONE edge: new result loads, no overrun
    run_conv(6'b000000, 6'b000111, 1'b1, 1'b0, 3'd0);
    check("dout_3", if_a.dout, 3);
    check("valid_3", if_a.dout_valid, 1);
    check("ovr_ready", ovr_a, 0);
    @(negedge clk); if_a.dout_ready = 1'b0;
    check("valid_after_xfer", if_a.dout_valid, 0);

    // Bubble in coarse word -> coarse saturates to 5
    run_conv(6'b000101, 6'b000000, 1'b1, 1'b1, 3'd5);
    check("dout_30", if_a.dout, 30);
    check("bub_set", bub_a, 1);
    @(negedge clk); clr_a = 1'b1; if_a.dout_ready = 1'b0;
    @(negedge clk); clr_a = 1'b0;
    check("bub_clr", bub_a, 0);

    // Bubble set on the same edge as err_clr wins; held err_clr then clears it
    clr_a = 1'b1;
    run_conv(6'b000001, 6'b010000, 1'b0, 1'b1, 3'd1);
    check("bub_set_vs_clr", bub_e10, 1);
    check("bub_held_clr", bub_a, 0);
    check("dout_11", if_a.dout, 11);
    clr_a = 1'b0;
    @(negedge clk); if_a.dout_ready = 1'b1;
    @(negedge clk); if_a.dout_ready = 1'b0;

    // Overrange both words
    run_conv(6'b111111, 6'b111111, 1'b0, 1'b1, 3'd5);
    check("dout_35", if_a.dout, 35);
    check("bub_35", bub_a, 0);
    @(negedge clk); if_a.dout_ready = 1'b1;
    @(negedge clk); if_a.dout_ready = 1'b0;

    // start pulsed during F_SETTLE is not queued
    @(negedge clk); start_a = 1'b1; comp_a = 6'b000001;
    @(negedge clk); start_a = 1'b0;
    repeat (7) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("busy_e8", busy_a, 1);
    repeat (3) @(negedge clk);
    check("valid_ign", if_a.dout_valid, 1);
    @(negedge clk);
    check("busy_ign", busy_a, 0);
    check("sample_ign", smp_a, 0);

    // Reset in F_SETTLE with a pending result
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (7) @(negedge clk);
    check("dac_pre_rst", dac_a, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_sample", smp_a, 0);
    check("mid_rst_dac", dac_a, 0);
    check("mid_rst_valid", if_a.dout_valid, 0);

    // Minimum timing, start held: latency 6, period 7
    start_b = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("b_valid_e%0d", k), if_b.dout_valid, (k == 6 || k == 13) ? 1 : 0);
      if (k == 6) check("b_dout_7", if_b.dout, 7);
    end
    start_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
